matrix_fetch_unit: RTL and testbench
====================================

// Module: matrix_fetch_unit
// PURPOSE
//  Parametrised successor fetch stage for the SIMD core. Loads N-row matrices B then A through a
//  valid/ready row port into internal banks, fetches instructions by PC from sync instruction memory,
//  starts the execute unit, waits for DONE and drains N result rows to DATAOUT with a handshake.
//  Sits between host/memory and the NxN SIMD execute array.
// PARAMETERS
//  N        16            lanes per row = matrix dimension (power of 2, >=2)
//  DW       32            data/instruction word width
//  REGN     512           instruction store size; PCW = $clog2(REGN/2)
//  PC_BASE  0             PC value after reset and after HALT
// PORTS
//  CLK        in   1          clock, rising edge
//  RSTN       in   1          async active-low reset
//  GO         in   1          leave IDLE, begin matrix load
//  MAT_IN     in   N*DW       one matrix row, lane i = MAT_IN[i]
//  MAT_VALID  in   1          row valid
//  MAT_READY  out  1          row accepted when VALID&READY
//  PC_INS     out  PCW        instruction address
//  INSTRDATA  in   DW         instruction memory read data, 1-cycle latency
//  INSTR      out  DW         registered current instruction
//  START      out  1          1-cycle pulse to execute unit
//  DONE       in   1          execute unit complete
//  MAT_A_OUT  out  N*N*DW     bank A contents
//  MAT_B_OUT  out  N*N*DW     bank B contents
//  RES_IDX    out  $clog2(N)  result row index requested from execute unit
//  RESULT     in   N*DW       result row selected by RES_IDX (combinational from execute)
//  DATAOUT    out  N*DW       registered result row
//  DOUT_VALID out  1          DATAOUT valid
//  DOUT_READY in   1          consumer accepts DATAOUT
//  BUSY       out  1          state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; PC_INS=PC_BASE; INSTR, DATAOUT, banks, row counter, RES_IDX = 0; all strobes 0.
//  FSM: IDLE -GO-> LOAD_B -N rows-> LOAD_A -N rows-> FETCH -> EXEC -> DRAIN -> FETCH | LOAD_B | IDLE.
//  LOAD_x: MAT_READY=1; each handshake writes row[cnt], cnt++; on cnt==N-1 handshake go next, cnt=0.
//   MAT_VALID outside LOAD_x ignored, MAT_READY=0.
//  FETCH: 2 cycles; cycle1 PC_INS stable, cycle2 INSTR<=INSTRDATA. INSTR==0 (HALT): PC<=PC_BASE,
//   go IDLE, no START. Else EXEC with START pulse on first EXEC cycle.
//  EXEC: hold until DONE=1 (DONE on START cycle is honoured); DONE outside EXEC ignored.
//  DRAIN: RES_IDX=r, DATAOUT<=RESULT, DOUT_VALID=1; on DOUT_READY advance r; stall holds DATAOUT.
//   After row N-1 handshake: PC<=PC+1 (wraps REGN/2-1 -> 0); INSTR[DW-1]=1 -> LOAD_B (reload) else FETCH.
//  Latency GO->first MAT_READY: 1 cycle. DONE->first DOUT_VALID: 1 cycle. Back-to-back rows accepted
//   every cycle in LOAD and DRAIN.
//  Reset mid-operation: immediate return to reset values; partially loaded banks cleared.
// CONFIGURATION
//  TRANSPOSE_B_EN defined: LOAD_B handshake k writes column k of bank B (MAT_B_OUT[i][k]=MAT_IN[i]).
//  Undefined: bank B written row-wise like bank A. Bank A always row-wise.
// STRUCTURE
//  Package fetch_pkg: state_t enum, OP_HALT = '0, RELOAD_BIT = DW-1, PCW/row-index width functions.
//  Sub-module fetch_row_bank (N x N x DW register bank, row write port, optional column write
//   port under TRANSPOSE_B_EN); instantiated twice (A, B). FSM, PC and drain logic stay in top.
// TESTING
//  Reset: RSTN=0 mid-LOAD_A -> PC_INS=0, BUSY=0, MAT_A_OUT/MAT_B_OUT all zero, MAT_READY=0.
//  Load: GO, rows B=k*16+{1..16}, A=k*16+{13..} with VALID toggling -> banks exact, no row lost/duplicated.
//  Fetch/exec: INSTRDATA=32'd5 at PC 0 -> INSTR=5, single START pulse; DONE after 3 cycles -> DRAIN.
//  Drain backpressure: DOUT_READY low 2 cycles on row 3 -> DATAOUT held, RES_IDX=3; then PC_INS=1.
//  HALT/reload: INSTR=32'h8000_0002 -> after drain LOAD_B; INSTR=0 -> IDLE, PC_INS=0, no START.
//  TRANSPOSE_B_EN: B row0 = {1..16} -> MAT_B_OUT[i][0]=i+1; without macro MAT_B_OUT[0][i]=i+1.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and helpers for the matrix fetch unit.
//   state_t     : fetch FSM state encoding
//   OP_HALT     : all-zero instruction word (compare against the low DW bits)
//   reload_bit  : bit of the instruction that requests a matrix reload (DW-1)
//   pc_width    : PC width for an instruction store of REGN entries
//   idx_width   : row-index width for an N-row matrix
// ---------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_B = 3'd1,
      ST_LOAD_A = 3'd2,
      ST_FETCH1 = 3'd3,
      ST_FETCH2 = 3'd4,
      ST_EXEC   = 3'd5,
      ST_DRAIN  = 3'd6
   } state_t;

   localparam int unsigned OP_W_MAX = 64;
   localparam logic [OP_W_MAX-1:0] OP_HALT = '0;

   function automatic int reload_bit(input int dw);
      return dw - 1;
   endfunction

   function automatic int pc_width(input int regn);
      return $clog2(regn / 2);
   endfunction

   function automatic int idx_width(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/fetch_row_bank.sv
// ---------------------------------------------------------------------------
// fetch_row_bank
// N x N x DW register bank. Element [r][c] lives at mat[(r*N+c)*DW +: DW].
// Optional macro: TRANSPOSE_B_EN adds a column write port.
// Ports:
//   clk, rst_n : clock, async active-low reset (bank cleared)
//   row_we     : write din lanes into row idx
//   col_we     : (TRANSPOSE_B_EN only) write din lane i into element [i][idx]
//   idx        : row / column index being written
//   din        : N lanes of DW bits, lane i = din[i*DW +: DW]
//   mat        : full bank contents
// ---------------------------------------------------------------------------
module fetch_row_bank
   import fetch_pkg::*;
#(
   parameter int N  = 16,
   parameter int DW = 32,
   localparam int IW = idx_width(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              row_we,
`ifdef TRANSPOSE_B_EN
   input  logic              col_we,
`endif
   input  logic [IW-1:0]     idx,
   input  logic [N*DW-1:0]   din,
   output logic [N*N*DW-1:0] mat
);

   logic [N*N*DW-1:0] mat_q;
   logic [N*N*DW-1:0] mat_d;

   // Next bank contents: one row (or column) replaced per write strobe.
   always_comb begin
      mat_d = mat_q;
      if (row_we) begin
         for (int i = 0; i < N; i++) begin
            mat_d[(int'(idx) * N + i) * DW +: DW] = din[i * DW +: DW];
         end
      end
`ifdef TRANSPOSE_B_EN
      else if (col_we) begin
         for (int i = 0; i < N; i++) begin
            mat_d[(i * N + int'(idx)) * DW +: DW] = din[i * DW +: DW];
         end
      end
`endif
      else begin
         mat_d = mat_q;
      end
   end

   // Bank storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mat_q <= '0;
      end else begin
         mat_q <= mat_d;
      end
   end

   assign mat = mat_q;

endmodule

// File: rtl/matrix_fetch_unit.sv
// ---------------------------------------------------------------------------
// matrix_fetch_unit
// Fetch stage for the SIMD core: loads matrix B then A row by row, fetches an
// instruction at PC, starts the execute array, waits for DONE and drains the
// N result rows through a valid/ready output.
// Optional macro: TRANSPOSE_B_EN -- row k of the B load lands in column k.
// Ports:
//   CLK, RSTN              : clock, async active-low reset
//   GO                     : leave IDLE and start loading
//   MAT_IN/VALID/READY     : row input handshake (B rows then A rows)
//   PC_INS, INSTRDATA      : sync instruction memory (1-cycle read latency)
//   INSTR                  : registered current instruction
//   START, DONE            : execute-unit pulse / completion
//   MAT_A_OUT, MAT_B_OUT   : bank contents for the execute array
//   RES_IDX, RESULT        : result row select / combinational row returned
//   DATAOUT/VALID/READY    : result row output handshake
//   BUSY                   : FSM not idle
// ---------------------------------------------------------------------------
module matrix_fetch_unit
   import fetch_pkg::*;
#(
   parameter int N       = 16,
   parameter int DW      = 32,
   parameter int REGN    = 512,
   parameter int PC_BASE = 0,
   localparam int PCW    = pc_width(REGN),
   localparam int IW     = idx_width(N)
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              GO,
   input  logic [N*DW-1:0]   MAT_IN,
   input  logic              MAT_VALID,
   output logic              MAT_READY,
   output logic [PCW-1:0]    PC_INS,
   input  logic [DW-1:0]     INSTRDATA,
   output logic [DW-1:0]     INSTR,
   output logic              START,
   input  logic              DONE,
   output logic [N*N*DW-1:0] MAT_A_OUT,
   output logic [N*N*DW-1:0] MAT_B_OUT,
   output logic [IW-1:0]     RES_IDX,
   input  logic [N*DW-1:0]   RESULT,
   output logic [N*DW-1:0]   DATAOUT,
   output logic              DOUT_VALID,
   input  logic              DOUT_READY,
   output logic              BUSY
);

   localparam int RELOAD_BIT = reload_bit(DW);

   state_t          state_q,   state_d;
   logic [IW-1:0]   row_q,     row_d;
   logic [PCW-1:0]  pc_q,      pc_d;
   logic [DW-1:0]   instr_q,   instr_d;
   logic [N*DW-1:0] dataout_q, dataout_d;
   logic            ready_q,   ready_d;
   logic            start_q,   start_d;
   logic            dvalid_q,  dvalid_d;
   logic            busy_q,    busy_d;

   logic            load_hs_s;
   logic            drain_hs_s;
   logic            last_row_s;
   logic            a_we_s;
   logic            b_we_s;
   logic [IW-1:0]   res_idx_s;

   assign load_hs_s  = MAT_VALID & ready_q;
   assign drain_hs_s = dvalid_q & DOUT_READY;
   assign last_row_s = (row_q == IW'(N - 1));
   assign a_we_s     = load_hs_s & (state_q == ST_LOAD_A);
   assign b_we_s     = load_hs_s & (state_q == ST_LOAD_B);
   // Look ahead to the next row on a handshake so RESULT already carries it
   // when DATAOUT reloads; this keeps the drain at one row per cycle.
   assign res_idx_s  = drain_hs_s ? (row_q + IW'(1)) : row_q;

   // Next-state, counters, PC and output strobes.
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      dataout_d = dataout_q;
      start_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (GO) begin
               state_d = ST_LOAD_B;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD_B, ST_LOAD_A: begin
            if (load_hs_s) begin
               if (last_row_s) begin
                  row_d   = '0;
                  state_d = (state_q == ST_LOAD_B) ? ST_LOAD_A : ST_FETCH1;
               end else begin
                  row_d = row_q + IW'(1);
               end
            end else begin
               row_d = row_q;
            end
         end
         ST_FETCH1: begin
            state_d = ST_FETCH2;
         end
         ST_FETCH2: begin
            instr_d = INSTRDATA;
            if (INSTRDATA == OP_HALT[DW-1:0]) begin
               pc_d    = PCW'(PC_BASE);
               state_d = ST_IDLE;
            end else begin
               start_d = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (DONE) begin
               row_d     = '0;
               dataout_d = RESULT;
               state_d   = ST_DRAIN;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_DRAIN: begin
            if (drain_hs_s) begin
               if (last_row_s) begin
                  row_d   = '0;
                  pc_d    = (pc_q == PCW'(REGN / 2 - 1)) ? '0 : (pc_q + PCW'(1));
                  state_d = instr_q[RELOAD_BIT] ? ST_LOAD_B : ST_FETCH1;
               end else begin
                  row_d     = row_q + IW'(1);
                  dataout_d = RESULT;
               end
            end else begin
               row_d = row_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      ready_d  = (state_d == ST_LOAD_B) || (state_d == ST_LOAD_A);
      dvalid_d = (state_d == ST_DRAIN);
      busy_d   = (state_d != ST_IDLE);
   end

   // State, PC, instruction, result and strobe registers.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q   <= ST_IDLE;
         row_q     <= '0;
         pc_q      <= PCW'(PC_BASE);
         instr_q   <= '0;
         dataout_q <= '0;
         ready_q   <= 1'b0;
         start_q   <= 1'b0;
         dvalid_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         dataout_q <= dataout_d;
         ready_q   <= ready_d;
         start_q   <= start_d;
         dvalid_q  <= dvalid_d;
         busy_q    <= busy_d;
      end
   end

   fetch_row_bank #(.N(N), .DW(DW)) u_bank_a (
      .clk    (CLK),
      .rst_n  (RSTN),
      .row_we (a_we_s),
`ifdef TRANSPOSE_B_EN
      .col_we (1'b0),
`endif
      .idx    (row_q),
      .din    (MAT_IN),
      .mat    (MAT_A_OUT)
   );

   fetch_row_bank #(.N(N), .DW(DW)) u_bank_b (
      .clk    (CLK),
      .rst_n  (RSTN),
`ifdef TRANSPOSE_B_EN
      .row_we (1'b0),
      .col_we (b_we_s),
`else
      .row_we (b_we_s),
`endif
      .idx    (row_q),
      .din    (MAT_IN),
      .mat    (MAT_B_OUT)
   );

   assign MAT_READY  = ready_q;
   assign PC_INS     = pc_q;
   assign INSTR      = instr_q;
   assign START      = start_q;
   assign RES_IDX    = res_idx_s;
   assign DATAOUT    = dataout_q;
   assign DOUT_VALID = dvalid_q;
   assign BUSY       = busy_q;

endmodule

// File: tb/tb_matrix_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_matrix_fetch_unit
// Drives matrix loads with random valid gaps, a behavioural instruction memory
// and execute unit, and checks banks, fetch, drain order and control flow
// against expectations computed from plain arrays.
// ---------------------------------------------------------------------------
module tb_matrix_fetch_unit;

   localparam int N    = 16;
   localparam int DW   = 32;
   localparam int REGN = 512;
   localparam int PCW  = $clog2(REGN / 2);
   localparam int IW   = $clog2(N);

   logic              clk = 1'b0;
   logic              rstn;
   logic              go;
   logic [N*DW-1:0]   mat_in;
   logic              mat_valid;
   logic              mat_ready;
   logic [PCW-1:0]    pc_ins;
   logic [DW-1:0]     instrdata;
   logic [DW-1:0]     instr;
   logic              start;
   logic              done;
   logic [N*N*DW-1:0] mat_a_out;
   logic [N*N*DW-1:0] mat_b_out;
   logic [IW-1:0]     res_idx;
   logic [N*DW-1:0]   result;
   logic [N*DW-1:0]   dataout;
   logic              dout_valid;
   logic              dout_ready;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] imem     [REGN/2];
   logic [DW-1:0] a_mdl    [N][N];
   logic [DW-1:0] b_mdl    [N][N];
   logic [DW-1:0] res_rows [N][N];

   matrix_fetch_unit #(.N(N), .DW(DW), .REGN(REGN), .PC_BASE(0)) dut (
      .CLK(clk), .RSTN(rstn), .GO(go),
      .MAT_IN(mat_in), .MAT_VALID(mat_valid), .MAT_READY(mat_ready),
      .PC_INS(pc_ins), .INSTRDATA(instrdata), .INSTR(instr),
      .START(start), .DONE(done),
      .MAT_A_OUT(mat_a_out), .MAT_B_OUT(mat_b_out),
      .RES_IDX(res_idx), .RESULT(result),
      .DATAOUT(dataout), .DOUT_VALID(dout_valid), .DOUT_READY(dout_ready),
      .BUSY(busy)
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory, one cycle of read latency.
   always @(posedge clk) instrdata <= imem[pc_ins];

   // Execute array: row selected by RES_IDX, combinational.
   for (genvar g = 0; g < N; g++) begin : g_res
      assign result[g*DW +: DW] = res_rows[res_idx][g];
   end

   function automatic logic [N*N*DW-1:0] pack_bank(input logic [DW-1:0] m [N][N]);
      logic [N*N*DW-1:0] v;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            v[(r*N + c)*DW +: DW] = m[r][c];
      return v;
   endfunction

   function automatic int first_diff(input logic [N*N*DW-1:0] x, input logic [N*N*DW-1:0] y);
      for (int e = 0; e < N*N; e++)
         if (x[e*DW +: DW] !== y[e*DW +: DW]) return e;
      return -1;
   endfunction

   task automatic fill_results();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            res_rows[r][c] = $urandom;
   endtask

   // Offers nrows rows (lane i of row k = k*16+base+i) with random valid gaps.
   task automatic load_rows(input bit is_b, input int base, input int nrows);
      int k = 0;
      int cyc = 0;
      bit v;
      logic [DW-1:0] lane [N];
      while (k < nrows && cyc < 40*N) begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < N; i++) lane[i] = DW'(k*16 + base + i);
         v = ($urandom_range(0, 2) != 0);
         mat_valid = v;
         for (int i = 0; i < N; i++) mat_in[i*DW +: DW] = v ? lane[i] : DW'($urandom);
         if (v && mat_ready) begin
            for (int i = 0; i < N; i++) begin
               if (is_b) begin
`ifdef TRANSPOSE_B_EN
                  b_mdl[i][k] = lane[i];
`else
                  b_mdl[k][i] = lane[i];
`endif
               end else begin
                  a_mdl[k][i] = lane[i];
               end
            end
            k++;
         end
      end
      n_checks++;
      if (k != nrows) begin
         n_fail++;
         $display("FAIL load_rows: accepted %0d rows, required %0d", k, nrows);
      end
   endtask

   // From FETCH1: waits for START, checks the instruction, raises DONE after done_delay cycles.
   task automatic exec_instr(input logic [DW-1:0] exp_instr, input int exp_pc, input int done_delay);
      bit seen = 1'b0;
      int pulses;
      int e;
      logic [N*N*DW-1:0] exp_bank;
      done = 1'b1;  // DONE outside EXEC must be ignored
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         done = 1'b0;
         mat_valid = 1'b1;
         mat_in = {N{DW'($urandom)}};
         if (start === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL start_seen: START got 0 required 1"); end
      n_checks++;
      if (instr !== exp_instr) begin n_fail++; $display("FAIL instr: got %h required %h", instr, exp_instr); end
      n_checks++;
      if (pc_ins !== PCW'(exp_pc)) begin n_fail++; $display("FAIL exec_pc: got %0d required %0d", pc_ins, exp_pc); end
      pulses = 1;
      for (int d = 0; d < done_delay; d++) begin
         @(negedge clk);
         if (start === 1'b1) pulses++;
         n_checks++;
         if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid: got %b required 0", dout_valid); end
      end
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      mat_valid = 1'b0;
      if (start === 1'b1) pulses++;
      n_checks++;
      if (pulses != 1) begin n_fail++; $display("FAIL start_pulses: got %0d required 1", pulses); end
      n_checks++;
      if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL done_to_valid: got %b required 1", dout_valid); end
      exp_bank = pack_bank(a_mdl);
      e = first_diff(mat_a_out, exp_bank);
      n_checks++;
      if (e >= 0) begin
         n_fail++;
         $display("FAIL bank_a_hold: element %0d got %h required %h", e, mat_a_out[e*DW +: DW], exp_bank[e*DW +: DW]);
      end
   endtask

   // Drains N rows, stalling row stall_row twice plus random stalls.
   task automatic drain(input int stall_row);
      int r = 0;
      int cyc = 0;
      int stalls = 0;
      bit rdy;
      logic [N*DW-1:0] held;
      for (int i = 0; i < N; i++) held[i*DW +: DW] = res_rows[0][i];
      while (r < N && cyc < 40*N) begin
         n_checks++;
         if (dout_valid !== 1'b1 || dataout !== held) begin
            n_fail++;
            $display("FAIL drain_row%0d: valid %b data %h required valid 1 data %h", r, dout_valid, dataout, held);
         end
         if (r == stall_row && stalls < 2) begin
            rdy = 1'b0;
            stalls++;
         end else begin
            rdy = ($urandom_range(0, 3) != 0);
         end
         dout_ready = rdy;
         #1;
         if (!rdy) begin
            n_checks++;
            if (res_idx !== IW'(r)) begin n_fail++; $display("FAIL res_idx_stall: got %0d required %0d", res_idx, r); end
            // A stalled row must stay put even if the execute side changes.
            if (r == stall_row) res_rows[r][0] = res_rows[r][0] ^ 32'hFFFF_FFFF;
         end else begin
            r++;
            if (r < N) for (int i = 0; i < N; i++) held[i*DW +: DW] = res_rows[r][i];
         end
         @(negedge clk);
         cyc++;
      end
      dout_ready = 1'b0;
      n_checks++;
      if (r != N) begin n_fail++; $display("FAIL drain_count: got %0d rows required %0d", r, N); end
      n_checks++;
      if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL drain_end_valid: got %b required 0", dout_valid); end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (pc_ins !== '0 || busy !== 1'b0 || mat_ready !== 1'b0 || start !== 1'b0 || dout_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: pc %0d busy %b ready %b start %b dvalid %b required all 0", pc_ins, busy, mat_ready, start, dout_valid);
      end
      n_checks++;
      if (instr !== '0 || dataout !== '0 || res_idx !== '0) begin
         n_fail++;
         $display("FAIL reset_data: instr %h res_idx %0d required 0", instr, res_idx);
      end
      n_checks++;
      if (mat_a_out !== '0 || mat_b_out !== '0) begin
         n_fail++;
         $display("FAIL reset_banks: got a_nonzero=%b b_nonzero=%b required 0 0", |mat_a_out, |mat_b_out);
      end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_load();
      int e;
      bit bad = 1'b0;
      logic [N*N*DW-1:0] exp_bank;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      n_checks++;
      if (mat_ready !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL go_latency: ready %b busy %b required 1 1", mat_ready, busy);
      end
      load_rows(1'b1, 1, N);
      load_rows(1'b0, 13, N);
      @(negedge clk);
      n_checks++;
      if (mat_ready !== 1'b0) begin n_fail++; $display("FAIL ready_after_load: got %b required 0", mat_ready); end
      exp_bank = pack_bank(a_mdl);
      e = first_diff(mat_a_out, exp_bank);
      n_checks++;
      if (e >= 0) begin
         n_fail++;
         $display("FAIL bank_a: element %0d got %h required %h", e, mat_a_out[e*DW +: DW], exp_bank[e*DW +: DW]);
      end
      exp_bank = pack_bank(b_mdl);
      e = first_diff(mat_b_out, exp_bank);
      n_checks++;
      if (e >= 0) begin
         n_fail++;
         $display("FAIL bank_b: element %0d got %h required %h", e, mat_b_out[e*DW +: DW], exp_bank[e*DW +: DW]);
      end
      for (int i = 0; i < N; i++) begin
`ifdef TRANSPOSE_B_EN
         if (mat_b_out[(i*N)*DW +: DW] !== DW'(i + 1)) bad = 1'b1;
`else
         if (mat_b_out[i*DW +: DW] !== DW'(i + 1)) bad = 1'b1;
`endif
      end
      n_checks++;
      if (bad) begin n_fail++; $display("FAIL b_row0_layout: got mismatching lane, required element value i+1"); end
   endtask

   task automatic test_fetch_exec();
      fill_results();
      exec_instr(32'd5, 0, 3);
   endtask

   task automatic test_drain_backpressure();
      drain(3);
      n_checks++;
      if (pc_ins !== PCW'(1) || busy !== 1'b1 || mat_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL after_drain: pc %0d busy %b ready %b required 1 1 0", pc_ins, busy, mat_ready);
      end
   endtask

   task automatic test_reload();
      fill_results();
      exec_instr(32'h8000_0002, 1, 0);
      drain($urandom_range(0, N-1));
      n_checks++;
      if (mat_ready !== 1'b1 || pc_ins !== PCW'(2) || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reload: ready %b pc %0d busy %b required 1 2 1", mat_ready, pc_ins, busy);
      end
   endtask

   task automatic test_reset_mid();
      load_rows(1'b1, 101, N);
      load_rows(1'b0, 113, 5);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      n_checks++;
      if (pc_ins !== '0 || busy !== 1'b0 || mat_ready !== 1'b0 || instr !== '0 || dataout !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_ctrl: pc %0d busy %b ready %b instr %h required 0 0 0 0", pc_ins, busy, mat_ready, instr);
      end
      n_checks++;
      if (mat_a_out !== '0 || mat_b_out !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_banks: got a_nonzero=%b b_nonzero=%b required 0 0", |mat_a_out, |mat_b_out);
      end
      mat_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_halt();
      int e;
      int pulses = 0;
      logic [N*N*DW-1:0] exp_bank;
      imem[0] = '0;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      load_rows(1'b1, 201, N);
      load_rows(1'b0, 213, N);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         mat_valid = 1'b1;
         mat_in = {N{DW'($urandom)}};
         done = (c == 3);
         if (start === 1'b1) pulses++;
      end
      mat_valid = 1'b0;
      done = 1'b0;
      n_checks++;
      if (pulses != 0) begin n_fail++; $display("FAIL halt_start: got %0d pulses required 0", pulses); end
      n_checks++;
      if (busy !== 1'b0 || pc_ins !== '0 || instr !== '0 || mat_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_state: busy %b pc %0d instr %h ready %b required 0 0 0 0", busy, pc_ins, instr, mat_ready);
      end
      exp_bank = pack_bank(b_mdl);
      e = first_diff(mat_b_out, exp_bank);
      n_checks++;
      if (e >= 0) begin
         n_fail++;
         $display("FAIL halt_bank_b: element %0d got %h required %h", e, mat_b_out[e*DW +: DW], exp_bank[e*DW +: DW]);
      end
   endtask

   initial begin
      go = 1'b0;
      mat_valid = 1'b0;
      mat_in = '0;
      done = 1'b0;
      dout_ready = 1'b0;
      for (int i = 0; i < REGN/2; i++) imem[i] = '0;
      imem[0] = 32'd5;
      imem[1] = 32'h8000_0002;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            res_rows[r][c] = '0;
            a_mdl[r][c] = '0;
            b_mdl[r][c] = '0;
         end
      test_reset();
      test_load();
      test_fetch_exec();
      test_drain_backpressure();
      test_reload();
      test_reset_mid();
      test_halt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
